// File: rtl/pcie_rx_cond_if.sv
// Serial-in / two-lane-out bundle for the PCIe-style receive conditioner.
// The master side drives the bitstream; the slave side produces the lane bytes.
interface pcie_rx_cond_if;
   logic       data_serial_in;
   logic       active;
   logic [7:0] data_out_0;
   logic       valid_out_0;
   logic [7:0] data_out_1;
   logic       valid_out_1;

   modport master (
      output data_serial_in,
      input  active,
      input  data_out_0,
      input  valid_out_0,
      input  data_out_1,
      input  valid_out_1
   );

   modport slave (
      input  data_serial_in,
      output active,
      output data_out_0,
      output valid_out_0,
      output data_out_1,
      output valid_out_1
   );
endinterface

// File: rtl/pcie_rx_cond.sv
// Receive conditioner: deserialize, align on comma, lock after BC_LOCK commas,
// then unstripe bytes alternately onto lane 0 / lane 1.
module pcie_rx_cond #(
   parameter logic [7:0]  COMMA   = 8'hBC,
   parameter int unsigned BC_LOCK = 4
) (
   input  logic         clk_8f,
   input  logic         reset,
   pcie_rx_cond_if.slave rx
);

   localparam logic [1:0] S_SEARCH = 2'd0;
   localparam logic [1:0] S_TRAIN  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] comma_cnt_q, comma_cnt_d;
   logic       lane_q, lane_d;
   logic       active_q, active_d;
   logic [7:0] d0_q, d0_d;
   logic [7:0] d1_q, d1_d;
   logic       v0_q, v0_d;
   logic       v1_q, v1_d;
   logic       boundary;
   logic       is_comma;

   always_comb begin
      sr_d        = {sr_q[6:0], rx.data_serial_in};
      boundary    = (bit_cnt_q == 3'd7);
      is_comma    = (sr_d == COMMA);
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q + 3'd1;
      comma_cnt_d = comma_cnt_q;
      lane_d      = lane_q;
      active_d    = active_q;
      d0_d        = d0_q;
      d1_d        = d1_q;
      v0_d        = 1'b0;
      v1_d        = 1'b0;
      unique case (state_q)
         S_SEARCH: begin
            // bit-granular hunt; a hit defines the byte boundary
            if (is_comma) begin
               state_d     = S_TRAIN;
               comma_cnt_d = 4'd1;
               bit_cnt_d   = 3'd0;
            end
         end
         S_TRAIN: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_cnt_d = comma_cnt_q + 4'd1;
                  if (comma_cnt_d == 4'(BC_LOCK)) begin
                     state_d  = S_LOCKED;
                     active_d = 1'b1;
                     lane_d   = 1'b0;
                  end
               end else begin
                  state_d     = S_SEARCH;
                  comma_cnt_d = 4'd0;
               end
            end
         end
         S_LOCKED: begin
            // idle commas consume a lane slot without a pulse
            if (boundary) begin
               lane_d = ~lane_q;
               if (!is_comma) begin
                  if (!lane_q) begin
                     d0_d = sr_d;
                     v0_d = 1'b1;
                  end else begin
                     d1_d = sr_d;
                     v1_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_SEARCH;
      endcase
   end

   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         state_q     <= S_SEARCH;
         sr_q        <= 8'h00;
         bit_cnt_q   <= 3'd0;
         comma_cnt_q <= 4'd0;
         lane_q      <= 1'b0;
         active_q    <= 1'b0;
         d0_q        <= 8'h00;
         d1_q        <= 8'h00;
         v0_q        <= 1'b0;
         v1_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         lane_q      <= lane_d;
         active_q    <= active_d;
         d0_q        <= d0_d;
         d1_q        <= d1_d;
         v0_q        <= v0_d;
         v1_q        <= v1_d;
      end
   end

   assign rx.active      = active_q;
   assign rx.data_out_0  = d0_q;
   assign rx.valid_out_0 = v0_q;
   assign rx.data_out_1  = d1_q;
   assign rx.valid_out_1 = v1_q;

endmodule

// File: tb/tb_pcie_rx_cond.sv
// Directed bench for pcie_rx_cond: a byte-vector table for lock and
// unstriping, plus hand sequences for misalignment, broken training and reset.
module tb_pcie_rx_cond;

   logic clk;
   logic rst_n;

   pcie_rx_cond_if rx ();

   pcie_rx_cond dut (
      .clk_8f (clk),
      .reset  (rst_n),
      .rx     (rx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      logic       act;
      logic       v0;
      logic       v1;
      logic [7:0] d0;
      logic [7:0] d1;
   } vec_t;

   vec_t vecs [12];

   int checks = 0;
   int errors = 0;

   logic       l_act, l_v0, l_v1;
   logic [7:0] l_d0, l_d1;
   int         early;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sample();
      l_act = rx.active;
      l_v0  = rx.valid_out_0;
      l_v1  = rx.valid_out_1;
      l_d0  = rx.data_out_0;
      l_d1  = rx.data_out_1;
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      rx.data_serial_in = b;
      @(posedge clk);
      #1;
      sample();
   endtask

   // early counts pulses on the first seven edges of the byte
   task automatic send_byte(input logic [7:0] b);
      early = 0;
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i]);
         if (i != 0 && (l_v0 || l_v1)) early++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rx.data_serial_in = 1'b0;
      @(posedge clk);
      #1;
      sample();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic vec_t mk(input logic [7:0] b, input logic act,
                               input logic v0, input logic v1,
                               input logic [7:0] d0, input logic [7:0] d1);
      vec_t v;
      v.b = b; v.act = act; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
      return v;
   endfunction

   initial begin
      rst_n = 1'b1;
      rx.data_serial_in = 1'b0;

      vecs[0]  = mk(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[1]  = mk(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[2]  = mk(8'hBC, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[3]  = mk(8'hBC, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      vecs[4]  = mk(8'h12, 1'b1, 1'b1, 1'b0, 8'h12, 8'h00);
      vecs[5]  = mk(8'h34, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
      vecs[6]  = mk(8'h56, 1'b1, 1'b1, 1'b0, 8'h56, 8'h34);
      vecs[7]  = mk(8'hBC, 1'b1, 1'b0, 1'b0, 8'h56, 8'h34);
      vecs[8]  = mk(8'hA1, 1'b1, 1'b1, 1'b0, 8'hA1, 8'h34);
      vecs[9]  = mk(8'hBC, 1'b1, 1'b0, 1'b0, 8'hA1, 8'h34);
      vecs[10] = mk(8'hA2, 1'b1, 1'b1, 1'b0, 8'hA2, 8'h34);
      vecs[11] = mk(8'hB3, 1'b1, 1'b0, 1'b1, 8'hA2, 8'hB3);

      repeat (2) @(posedge clk);
      do_reset();
      chk("rst_active", 32'(l_act), 32'd0);
      chk("rst_v0", 32'(l_v0), 32'd0);
      chk("rst_v1", 32'(l_v1), 32'd0);
      chk("rst_d0", 32'(l_d0), 32'h00);
      chk("rst_d1", 32'(l_d1), 32'h00);

      for (int i = 0; i < 12; i++) begin
         send_byte(vecs[i].b);
         chk($sformatf("vec%0d_active", i), 32'(l_act), 32'(vecs[i].act));
         chk($sformatf("vec%0d_v0", i), 32'(l_v0), 32'(vecs[i].v0));
         chk($sformatf("vec%0d_v1", i), 32'(l_v1), 32'(vecs[i].v1));
         chk($sformatf("vec%0d_d0", i), 32'(l_d0), 32'(vecs[i].d0));
         chk($sformatf("vec%0d_d1", i), 32'(l_d1), 32'(vecs[i].d1));
         chk($sformatf("vec%0d_early", i), 32'(early), 32'd0);
      end

      // reset mid-byte while locked
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset();
      chk("mid_rst_active", 32'(l_act), 32'd0);
      chk("mid_rst_d0", 32'(l_d0), 32'h00);
      chk("mid_rst_d1", 32'(l_d1), 32'h00);
      chk("mid_rst_v0", 32'(l_v0), 32'd0);
      chk("mid_rst_v1", 32'(l_v1), 32'd0);
      begin
         logic [7:0] traffic [5];
         traffic[0] = 8'h12; traffic[1] = 8'h34; traffic[2] = 8'hBC;
         traffic[3] = 8'h56; traffic[4] = 8'h77;
         for (int i = 0; i < 5; i++) begin
            send_byte(traffic[i]);
            chk($sformatf("post_rst%0d_active", i), 32'(l_act), 32'd0);
            chk($sformatf("post_rst%0d_pulses", i),
                32'(early + int'(l_v0) + int'(l_v1)), 32'd0);
         end
      end

      // misaligned start: junk 1,0,1 then four commas -> lock on bit 35
      do_reset();
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      chk("junk_3bc_active", 32'(l_act), 32'd0);
      begin
         logic [7:0] bc;
         bc = 8'hBC;
         for (int i = 7; i >= 1; i--) send_bit(bc[i]);
         chk("junk_bit34_active", 32'(l_act), 32'd0);
         send_bit(bc[0]);
         chk("junk_bit35_active", 32'(l_act), 32'd1);
         chk("junk_bit35_pulse", 32'(l_v0 | l_v1), 32'd0);
      end

      // broken training: 3 commas, a data byte, then 4 commas
      do_reset();
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      send_byte(8'h55);
      chk("brk_55_active", 32'(l_act), 32'd0);
      for (int i = 0; i < 3; i++) send_byte(8'hBC);
      chk("brk_3bc_active", 32'(l_act), 32'd0);
      send_byte(8'hBC);
      chk("brk_4bc_active", 32'(l_act), 32'd1);
      send_byte(8'h9A);
      chk("brk_first_v0", 32'(l_v0), 32'd1);
      chk("brk_first_d0", 32'(l_d0), 32'h9A);
      chk("brk_first_v1", 32'(l_v1), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
